// File: rtl/alu_mult_div_pkg.sv
// Shared opcodes, FSM states and opcode decode for the multiply/divide unit.
package alu_mult_div_pkg;

    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1a;
    localparam logic [5:0] OP_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        K_NONE,
        K_MULT,
        K_MULTU,
        K_DIV,
        K_DIVU,
        K_MTHI,
        K_MTLO
    } op_kind_t;

    // Code is zero-extended so any opcode bus width maps onto the same table.
    function automatic op_kind_t decode_op(input logic [31:0] code);
        op_kind_t k;
        k = K_NONE;
        if (code == 32'(OP_MULT))       k = K_MULT;
        else if (code == 32'(OP_MULTU)) k = K_MULTU;
        else if (code == 32'(OP_DIV))   k = K_DIV;
        else if (code == 32'(OP_DIVU))  k = K_DIVU;
        else if (code == 32'(OP_MTHI))  k = K_MTHI;
        else if (code == 32'(OP_MTLO))  k = K_MTLO;
        return k;
    endfunction

endpackage

// File: rtl/alu_mult_div_if.sv
// Request/response bundle between the EX-stage control and the multiply/divide unit.
interface alu_mult_div_if #(
    parameter int unsigned B_DAT = 32,
    parameter int unsigned B_OP  = 6
);
    logic             start;
    logic [B_OP-1:0]  op;
    logic [B_DAT-1:0] a;
    logic [B_DAT-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [B_DAT-1:0] hi;
    logic [B_DAT-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/alu_md_datapath.sv
// Accumulator, shift-add / restoring-divide step and final sign correction.
// ALU_FAST_MULT_EN: product formed directly from the latched magnitudes.
module alu_md_datapath
    import alu_mult_div_pkg::*;
#(
    parameter int unsigned B_DAT = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic             is_sgn,
    input  logic             b_zero,
    input  logic [B_DAT-1:0] a,
    input  logic [B_DAT-1:0] b,
    output logic [B_DAT-1:0] res_hi,
    output logic [B_DAT-1:0] res_lo
);
    localparam logic [B_DAT-1:0] ALL0 = '0;
    localparam logic [B_DAT-1:0] ALL1 = '1;

    logic [2*B_DAT-1:0] acc_q, acc_step, prod_mag, prod;
    logic [B_DAT-1:0]   m_q, ua, ub, rem_new;
    logic [B_DAT:0]     sum, sh, trial;
    logic               div_q, sa_q, sb_q, neg;

    assign ua = (is_sgn && a[B_DAT-1]) ? -a : a;
    assign ub = (is_sgn && b[B_DAT-1]) ? -b : b;

    always_comb begin
        sum      = {1'b0, acc_q[2*B_DAT-1:B_DAT]} + (acc_q[0] ? {1'b0, m_q} : {1'b0, ALL0});
        sh       = acc_q[2*B_DAT-1:B_DAT-1];
        trial    = sh - {1'b0, m_q};
        rem_new  = trial[B_DAT] ? sh[B_DAT-1:0] : trial[B_DAT-1:0];
        acc_step = div_q ? {rem_new, acc_q[B_DAT-2:0], ~trial[B_DAT]}
                         : {sum, acc_q[B_DAT-1:1]};
    end

    // Divide by zero preloads remainder=|a| and quotient=all ones, so the
    // common sign fix yields hi=a and lo=+1 for a negative signed dividend.
    always_ff @(posedge clk) begin
        if (load) begin
            div_q <= is_div;
            sa_q  <= is_sgn & a[B_DAT-1];
            sb_q  <= is_sgn & b[B_DAT-1];
            if (is_div) begin
                m_q   <= ub;
                acc_q <= b_zero ? {ua, ALL1} : {ALL0, ua};
            end else begin
                m_q   <= ua;
                acc_q <= {ALL0, ub};
            end
        end else if (step) begin
            acc_q <= acc_step;
        end
    end

`ifdef ALU_FAST_MULT_EN
    assign prod_mag = (2*B_DAT)'(m_q) * (2*B_DAT)'(acc_q[B_DAT-1:0]);
`else
    assign prod_mag = acc_q;
`endif

    assign neg  = sa_q ^ sb_q;
    assign prod = neg ? -prod_mag : prod_mag;

    always_comb begin
        if (div_q) begin
            res_lo = neg  ? -acc_q[B_DAT-1:0]       : acc_q[B_DAT-1:0];
            res_hi = sa_q ? -acc_q[2*B_DAT-1:B_DAT] : acc_q[2*B_DAT-1:B_DAT];
        end else begin
            res_hi = prod[2*B_DAT-1:B_DAT];
            res_lo = prod[B_DAT-1:0];
        end
    end
endmodule

// File: rtl/alu_mult_div.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
// ALU_FAST_MULT_EN: multiplies skip CALC and finish at T+2.
module alu_mult_div
    import alu_mult_div_pkg::*;
#(
    parameter int unsigned B_DAT = 32,
    parameter int unsigned B_OP  = 6,
    parameter int unsigned B_CNT = 6
) (
    input logic           clk,
    input logic           rst_n,
    alu_mult_div_if.slave bus
);
    state_t           state_q, state_d;
    op_kind_t         kind;
    logic [B_OP-1:0]  op_w;
    logic [B_CNT-1:0] cnt_q;
    logic [B_DAT-1:0] hi_q, lo_q, res_hi, res_lo;
    logic             div_zero_q;
    logic             ready, accept, is_mt, is_div, is_sgn, b_zero, skip_calc;
    logic             load, step, busy, done;

    assign op_w   = bus.op;
    assign kind   = decode_op(32'(op_w));
    assign is_mt  = (kind == K_MTHI) || (kind == K_MTLO);
    assign is_div = (kind == K_DIV) || (kind == K_DIVU);
    assign is_sgn = (kind == K_MULT) || (kind == K_DIV);
    assign b_zero = (bus.b == '0);
    assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept = bus.start && ready && (kind != K_NONE);

`ifdef ALU_FAST_MULT_EN
    assign skip_calc = !is_div || b_zero;
`else
    assign skip_calc = is_div && b_zero;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // DONE accepts a new request exactly like IDLE, giving back-to-back issue.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (is_mt)          state_d = S_DONE;
                    else if (skip_calc) state_d = S_FIX;
                    else                state_d = S_CALC;
                end
            end
            S_CALC:  if (cnt_q == B_CNT'(1)) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_CALC) || (state_q == S_FIX);
        done = (state_q == S_DONE);
        load = accept && !is_mt;
        step = (state_q == S_CALC);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            if (load)      cnt_q <= B_CNT'(B_DAT);
            else if (step) cnt_q <= cnt_q - B_CNT'(1);
            if (accept && is_div && b_zero) div_zero_q <= 1'b1;
            if (state_q == S_FIX) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (accept && kind == K_MTHI) begin
                hi_q <= bus.a;
            end else if (accept && kind == K_MTLO) begin
                lo_q <= bus.a;
            end
        end
    end

    alu_md_datapath #(
        .B_DAT(B_DAT)
    ) u_dp (
        .clk    (clk),
        .load   (load),
        .step   (step),
        .is_div (is_div),
        .is_sgn (is_sgn),
        .b_zero (b_zero),
        .a      (bus.a),
        .b      (bus.b),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_alu_mult_div.sv
// Directed plus randomized checks of alu_mult_div against an arithmetic reference model.
module tb_alu_mult_div;
    import alu_mult_div_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic [31:0] m_hi, m_lo;
    logic        m_dz;

    alu_mult_div_if #(.B_DAT(32), .B_OP(6)) bus ();

    alu_mult_div #(
        .B_DAT(32),
        .B_OP (6),
        .B_CNT(6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {hi, lo} after the operation, from MIPS arithmetic rules.
    function automatic logic [63:0] ref_result(input logic [5:0] op, input logic [31:0] a,
                                                input logic [31:0] b, input logic [31:0] chi,
                                                input logic [31:0] clo);
        int sa, sb, q, r;
        longint p;
        sa = a;
        sb = b;
        case (op)
            OP_MULT: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) return {a, (sa < 0) ? 32'd1 : 32'hffffffff};
                if (a == 32'h80000000 && b == 32'hffffffff) return {32'd0, 32'h80000000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hffffffff};
                return {a % b, a / b};
            end
            OP_MTHI: return {a, clo};
            OP_MTLO: return {chi, a};
            default: return {chi, clo};
        endcase
    endfunction

    function automatic int ref_lat(input logic [5:0] op, input logic [31:0] b);
        if (op == OP_MTHI || op == OP_MTLO) return 1;
        if ((op == OP_DIV || op == OP_DIVU) && b == 32'd0) return 2;
`ifdef ALU_FAST_MULT_EN
        if (op == OP_MULT || op == OP_MULTU) return 2;
`endif
        return 32 + 2;
    endfunction

    // Entered and left #1 after a rising edge, so consecutive calls issue back-to-back.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int poke);
        logic [63:0] exp;
        int lat, k;
        bit busy_bad, seen;
        exp = ref_result(op, a, b, m_hi, m_lo);
        lat = ref_lat(op, b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        if ((op == OP_DIV || op == OP_DIVU) && b == 32'd0) m_dz = 1'b1;
        k = 1;
        seen = 0;
        busy_bad = 0;
        while (k <= 60) begin
            if (bus.done === 1'b1) begin
                seen = 1;
                break;
            end
            if (bus.busy !== 1'b1) busy_bad = 1;
            if (k == poke) begin
                bus.start = 1'b1;
                bus.op    = OP_MTHI;
                bus.a     = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        bus.start = 1'b0;
        chk({tag, "/done_seen"}, 64'(seen), 64'd1);
        chk({tag, "/latency"}, 64'(k), 64'(lat));
        chk({tag, "/busy_in_flight"}, 64'(busy_bad), 64'd0);
        chk({tag, "/busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({tag, "/hi"}, 64'(bus.hi), 64'(exp[63:32]));
        chk({tag, "/lo"}, 64'(bus.lo), 64'(exp[31:0]));
        chk({tag, "/div_zero"}, 64'(bus.div_zero), 64'(m_dz));
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        logic [5:0]  ops [6];
        logic [5:0]  rop;
        logic [31:0] ra, rb;
        bit bad_done, bad_busy;
        vectors     = 0;
        miscompares = 0;
        ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
        m_hi = 32'd0;
        m_lo = 32'd0;
        m_dz = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 6'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/busy", 64'(bus.busy), 64'd0);
        chk("reset/done", 64'(bus.done), 64'd0);
        chk("reset/div_zero", 64'(bus.div_zero), 64'd0);
        chk("reset/hi", 64'(bus.hi), 64'd0);
        chk("reset/lo", 64'(bus.lo), 64'd0);
        rst_n = 1'b1;

        run_op("multu_max", OP_MULTU, 32'hffffffff, 32'hffffffff, 0);
        run_op("mult_neg7x3", OP_MULT, 32'hfffffff9, 32'd3, 0);
        run_op("div_neg7by2", OP_DIV, 32'hfffffff9, 32'd2, 0);
        run_op("divu_100by7", OP_DIVU, 32'd100, 32'd7, 0);
        run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 0);
        run_op("mult_after_dz", OP_MULT, 32'd6, 32'hfffffffe, 0);
        run_op("div_neg_by0", OP_DIV, 32'hfffffff0, 32'd0, 0);
        run_op("mthi", OP_MTHI, 32'h12345678, 32'd0, 0);
        run_op("mtlo", OP_MTLO, 32'hcafef00d, 32'd0, 0);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hffffffff, 0);
        run_op("mult_busy_start", OP_MULT, 32'h7fffffff, 32'h80000000, 1);

        bus.start = 1'b1;
        bus.op    = 6'h20;
        bus.a     = 32'hdeadbeef;
        bus.b     = 32'h1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bad_done = 0;
        bad_busy = 0;
        repeat (6) begin
            if (bus.done !== 1'b0) bad_done = 1;
            if (bus.busy !== 1'b0) bad_busy = 1;
            @(posedge clk);
            #1;
        end
        chk("badop/done", 64'(bad_done), 64'd0);
        chk("badop/busy", 64'(bad_busy), 64'd0);
        chk("badop/hi", 64'(bus.hi), 64'(m_hi));
        chk("badop/lo", 64'(bus.lo), 64'(m_lo));

        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        m_dz = 1'b0;
        chk("midreset/busy", 64'(bus.busy), 64'd0);
        chk("midreset/done", 64'(bus.done), 64'd0);
        chk("midreset/hi", 64'(bus.hi), 64'd0);
        chk("midreset/lo", 64'(bus.lo), 64'd0);
        chk("midreset/div_zero", 64'(bus.div_zero), 64'd0);
        run_op("multu_3x4", OP_MULTU, 32'd3, 32'd4, 0);

        for (int i = 0; i < 40; i++) begin
            rop = ops[$urandom_range(0, 5)];
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = $urandom_range(1, 20);
                3:       rb = 32'hffffffff;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
            run_op("random", rop, ra, rb, (i % 3 == 0) ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
